// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the aFIFO: pops words, packs PACK of them into one wide
// beat and hands it downstream over valid/ready; a flush emits a partial beat.
module fifo_rd_packer #(
  parameter int unsigned DW   = 8,
  parameter int unsigned PACK = 4,
  parameter int unsigned CW   = $clog2(PACK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               empty,
  input  logic [DW-1:0]      data_out,
  output logic               pop,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW*PACK-1:0] out_data,
  output logic [CW-1:0]      out_cnt,
  output logic [15:0]        beats
);

  logic [PACK-1:0][DW-1:0] asm_q, asm_d;
  logic [PACK-1:0][DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic [15:0]             beats_q, beats_d;
  logic                    inflight_q;
  logic                    flush_pend_q, flush_pend_d;
  logic                    out_valid_q, out_valid_d;

  logic          free, full, xfer, accept;
  logic [CW-1:0] occ;

  always_comb begin
    free   = !out_valid_q || out_ready;
    full   = (cnt_q == CW'(PACK));
    xfer   = free && !inflight_q && (full || (flush_pend_q && (cnt_q != '0)));
    accept = out_valid_q && out_ready;
    occ    = cnt_q + CW'(inflight_q);
    // Gated by reset so the FIFO sees no read request while state is held clear.
    pop    = rst && !empty && !flush_pend_q && !flush && ((occ < CW'(PACK)) || xfer);

    asm_d        = asm_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;
    beats_d      = beats_q + 16'(accept);

    if (inflight_q) begin
      for (int unsigned i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) asm_d[i] = data_out;
      end
      cnt_d = cnt_q + 1'b1;
    end

    if (xfer) begin
      for (int unsigned i = 0; i < PACK; i++) begin
        out_data_d[i] = (CW'(i) < cnt_q) ? asm_q[i] : '0;
      end
      out_cnt_d   = cnt_q;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // A flush seen while one is already pending is absorbed, not re-armed.
    if (flush_pend_q) begin
      if (xfer || ((cnt_q == '0) && !inflight_q)) flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q        <= '0;
      out_data_q   <= '0;
      cnt_q        <= '0;
      out_cnt_q    <= '0;
      beats_q      <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      out_data_q   <= out_data_d;
      cnt_q        <= cnt_d;
      out_cnt_q    <= out_cnt_d;
      beats_q      <= beats_d;
      inflight_q   <= pop;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign beats     = beats_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a behavioural FIFO feeds the DUT, expected
// beats are queued by stimulus and a negedge monitor compares accepted beats.
module tb_fifo_rd_packer;

  localparam int unsigned DW   = 8;
  localparam int unsigned PACK = 4;
  localparam int unsigned CW   = $clog2(PACK + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               empty;
  logic [DW-1:0]      data_out = '0;
  logic               pop;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DW*PACK-1:0] out_data;
  logic [CW-1:0]      out_cnt;
  logic [15:0]        beats;

  fifo_rd_packer #(.DW(DW), .PACK(PACK), .CW(CW)) dut (
    .clk(clk), .rst(rst), .empty(empty), .data_out(data_out), .pop(pop),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .beats(beats)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: read data appears one cycle after pop is sampled.
  logic [DW-1:0] mem [0:1023];
  int unsigned wrp = 0;
  int unsigned rdp = 0;
  assign empty = (rdp == wrp);

  always @(posedge clk) begin
    if (pop) begin
      data_out <= mem[rdp];
      rdp      <= rdp + 1;
    end
  end

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned popcnt = 0;

  logic [DW*PACK-1:0] sb_data [$];
  logic [CW-1:0]      sb_cnt  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wrp] = w;
    wrp++;
  endtask

  task automatic expect_beat(input logic [DW*PACK-1:0] d, input logic [CW-1:0] c);
    sb_data.push_back(d);
    sb_cnt.push_back(c);
  endtask

  task automatic drain(input int unsigned limit, input bit rand_ready);
    int unsigned n = 0;
    while ((sb_data.size() != 0 || out_valid) && n < limit) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (n >= limit) check("drain_timeout", 64'(sb_data.size()), 64'd0);
  endtask

  // Monitor: compare each accepted beat, verify stall stability and pop legality.
  logic               prev_stall = 1'b0;
  logic [DW*PACK-1:0] prev_data;
  logic [CW-1:0]      prev_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_cnt", 64'(out_cnt), 64'(prev_cnt));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_cnt   = out_cnt;
      if (pop) begin
        popcnt++;
        check("pop_while_empty", 64'(empty), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (sb_data.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%0h cnt %0d expected no beat", out_data, out_cnt);
        end else begin
          check("beat_data", 64'(out_data), 64'(sb_data.pop_front()));
          check("beat_cnt", 64'(out_cnt), 64'(sb_cnt.pop_front()));
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    logic [DW*PACK-1:0] w;

    // Reset and idle with the FIFO empty.
    repeat (3) tick();
    rst = 1'b1;
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_pop", 64'(pop), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_beats", 64'(beats), 64'd0);
    end
    tick();

    // One full beat.
    out_ready = 1'b1;
    p0 = popcnt;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    expect_beat(32'h44332211, 3'd4);
    drain(50, 1'b0);
    repeat (3) tick();
    check("t2_pops", 64'(popcnt - p0), 64'd4);
    check("t2_beats", 64'(beats), 64'd1);

    // Backpressure: two beats held until out_ready rises.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    expect_beat(32'h04030201, 3'd4);
    expect_beat(32'h08070605, 3'd4);
    repeat (15) tick();
    @(negedge clk);
    check("t3_stall_pop", 64'(pop), 64'd0);
    check("t3_all_read", 64'(rdp), 64'(wrp));
    check("t3_stall_valid", 64'(out_valid), 64'd1);
    check("t3_stall_data", 64'(out_data), 64'h04030201);
    tick();
    out_ready = 1'b1;
    drain(50, 1'b0);
    check("t3_beats", 64'(beats), 64'd3);

    // Partial beat via flush.
    p0 = popcnt;
    push_word(8'hAA); push_word(8'hBB);
    repeat (6) tick();
    check("t4_no_beat_yet", 64'(out_valid), 64'd0);
    expect_beat(32'h0000BBAA, 3'd2);
    flush = 1'b1;
    @(negedge clk);
    check("t4_flush_nopop", 64'(pop), 64'd0);
    tick();
    flush = 1'b0;
    drain(50, 1'b0);
    check("t4_pops", 64'(popcnt - p0), 64'd2);
    check("t4_beats", 64'(beats), 64'd4);

    // Flush with nothing collected: no beat, pops resume after one pending cycle.
    flush = 1'b1;
    push_word(8'h10); push_word(8'h20); push_word(8'h30); push_word(8'h40);
    expect_beat(32'h40302010, 3'd4);
    @(negedge clk);
    check("t5_pop_flush", 64'(pop), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t5_pop_pend", 64'(pop), 64'd0);
    @(negedge clk);
    check("t5_pop_resume", 64'(pop), 64'd1);
    drain(50, 1'b0);
    check("t5_beats", 64'(beats), 64'd5);

    // 400-word stream with random backpressure.
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < 4; k++) begin
        w[k*8 +: 8] = 8'((b * 4 + k) * 37 + 5);
        push_word(w[k*8 +: 8]);
      end
      expect_beat(w, 3'd4);
    end
    drain(4000, 1'b1);
    check("t6_beats", 64'(beats), 64'd105);
    check("t6_fifo_drained", 64'(rdp), 64'(wrp));

    // Reset while a word is in flight.
    push_word(8'h51); push_word(8'h52); push_word(8'h53);
    push_word(8'h54); push_word(8'h55);
    tick();
    rst = 1'b0;
    #1;
    check("t7_rst_pop", 64'(pop), 64'd0);
    check("t7_rst_valid", 64'(out_valid), 64'd0);
    check("t7_rst_data", 64'(out_data), 64'd0);
    check("t7_rst_cnt", 64'(out_cnt), 64'd0);
    check("t7_rst_beats", 64'(beats), 64'd0);
    tick();
    tick();
    expect_beat(32'h55545352, 3'd4);
    rst = 1'b1;
    drain(50, 1'b0);
    check("t7_beats", 64'(beats), 64'd1);
    check("sb_empty", 64'(sb_data.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
